// File: rtl/sb_tx_serializer.sv
// Sideband TX serializer: shifts 10-bit framed symbols LSB first onto sbtx,
// runs a serial CRC-16 over payload data bits and substitutes CRC bytes on request.
module sb_tx_serializer #(
  parameter logic [15:0] CRC_SEED = 16'hFFFF,
  parameter logic [15:0] CRC_POLY = 16'h8005
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic [9:0]  trans,
  input  logic [1:0]  trans_state,
  input  logic        crc_en,
  input  logic        sbtx_sel,
  input  logic        disconnected_s,
  output logic        sbtx,
  output logic        sym_done,
  output logic [15:0] crc_value,
  output logic        busy
);

  localparam int unsigned SYM_W = 10;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned CRC_W = 16;

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [1:0] TS_DISC    = 2'd0;
  localparam logic [1:0] TS_STARTED = 2'd2;

  localparam logic [CNT_W-1:0] FIRST_DATA = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(8);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(9);

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [SYM_W-1:0] shift_reg, shift_nxt;
  logic             cur_crc_en, cur_crc_en_nxt;
  logic             cur_sel, cur_sel_nxt;
  logic             crc_hi_done, crc_hi_done_nxt;
  logic [CRC_W-1:0] crc, crc_nxt;
  logic             sbtx_nxt;
  logic             sym_done_nxt;

  logic force_off;
  logic started;
  logic sym_end;
  logic load;
  logic data_bit;

  function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
    logic fb;
    fb = c[CRC_W-1] ^ b;
    return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : CRC_W'(0));
  endfunction

  assign force_off = disconnected_s | (trans_state == TS_DISC);
  assign started   = (trans_state == TS_STARTED);
  assign sym_end   = (state == ST_SHIFT) && (bit_cnt == LAST_BIT);
  assign load      = !force_off && started && ((state == ST_IDLE) || sym_end);
  assign data_bit  = (state == ST_SHIFT) && (bit_cnt >= FIRST_DATA) && (bit_cnt <= LAST_DATA);

  // Next-state, symbol load and CRC update
  always_comb begin
    state_nxt       = state;
    bit_cnt_nxt     = bit_cnt;
    shift_nxt       = shift_reg;
    cur_crc_en_nxt  = cur_crc_en;
    cur_sel_nxt     = cur_sel;
    crc_hi_done_nxt = crc_hi_done;
    crc_nxt         = crc;
    sbtx_nxt        = 1'b0;
    sym_done_nxt    = 1'b0;

    if (force_off) begin
      state_nxt       = ST_OFF;
      bit_cnt_nxt     = '0;
      shift_nxt       = '1;
      cur_crc_en_nxt  = 1'b0;
      cur_sel_nxt     = 1'b0;
      crc_hi_done_nxt = 1'b0;
      crc_nxt         = CRC_SEED;
    end else begin
      case (state)
        ST_OFF:   state_nxt = ST_IDLE;
        ST_IDLE:  if (started) state_nxt = ST_SHIFT;
        ST_SHIFT: begin
          if (sym_end) state_nxt = started ? ST_SHIFT : ST_IDLE;
          bit_cnt_nxt = sym_end ? '0 : CNT_W'(bit_cnt + CNT_W'(1));
        end
        default:  state_nxt = ST_OFF;
      endcase

      if (data_bit && cur_crc_en && !cur_sel)
        crc_nxt = crc_step(crc, shift_reg[bit_cnt]);

      if (load) begin
        bit_cnt_nxt    = '0;
        cur_crc_en_nxt = crc_en;
        cur_sel_nxt    = sbtx_sel;
        if (sbtx_sel) begin
          // High byte first; any later consecutive CRC slot repeats the low byte
          shift_nxt       = {1'b1, (crc_hi_done ? crc[7:0] : crc[15:8]), 1'b0};
          crc_hi_done_nxt = 1'b1;
        end else begin
          shift_nxt       = trans;
          crc_hi_done_nxt = 1'b0;
          if (!crc_en) crc_nxt = CRC_SEED;
        end
      end
    end

    case (state_nxt)
      ST_SHIFT: sbtx_nxt = shift_nxt[bit_cnt_nxt];
      ST_IDLE:  sbtx_nxt = 1'b1;
      default:  sbtx_nxt = 1'b0;
    endcase
    sym_done_nxt = (state_nxt == ST_SHIFT) && (bit_cnt_nxt == LAST_BIT);
  end

  always_ff @(posedge sb_clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_OFF;
      bit_cnt     <= '0;
      shift_reg   <= '1;
      cur_crc_en  <= 1'b0;
      cur_sel     <= 1'b0;
      crc_hi_done <= 1'b0;
      crc         <= CRC_SEED;
      sbtx        <= 1'b0;
      sym_done    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift_reg   <= shift_nxt;
      cur_crc_en  <= cur_crc_en_nxt;
      cur_sel     <= cur_sel_nxt;
      crc_hi_done <= crc_hi_done_nxt;
      crc         <= crc_nxt;
      sbtx        <= sbtx_nxt;
      sym_done    <= sym_done_nxt;
      busy        <= (state_nxt == ST_SHIFT);
    end
  end

  assign crc_value = crc;

endmodule

// File: tb/tb_sb_tx_serializer.sv
// Directed bench for sb_tx_serializer: LT/AT symbol streams, CRC slots,
// disconnect and reset truncation.
module tb_sb_tx_serializer;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic [9:0]  trans;
  logic [1:0]  trans_state;
  logic        crc_en;
  logic        sbtx_sel;
  logic        disconnected_s;
  logic        sbtx;
  logic        sym_done;
  logic [15:0] crc_value;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic [15:0] golden;

  sb_tx_serializer dut (
    .sb_clk         (sb_clk),
    .rst            (rst),
    .trans          (trans),
    .trans_state    (trans_state),
    .crc_en         (crc_en),
    .sbtx_sel       (sbtx_sel),
    .disconnected_s (disconnected_s),
    .sbtx           (sbtx),
    .sym_done       (sym_done),
    .crc_value      (crc_value),
    .busy           (busy)
  );

  always #5 sb_clk = ~sb_clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sb_clk);
    #1;
  endtask

  function automatic logic [9:0] frame(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  // Reference serial CRC-16 (poly 8005), data bits LSB first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  // Present one symbol and check all ten line bits; trans is scrambled mid-symbol
  task automatic send_sym(input string tag, input logic [9:0] sym, input logic en,
                          input logic sel, input logic [9:0] exp_bits);
    trans       = sym;
    crc_en      = en;
    sbtx_sel    = sel;
    trans_state = 2'd2;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) trans = ~sym;
      check($sformatf("%s_bit%0d", tag, i), 16'(sbtx), 16'(exp_bits[i]));
      check($sformatf("%s_done%0d", tag, i), 16'(sym_done), 16'(i == 9));
      check($sformatf("%s_busy%0d", tag, i), 16'(busy), 16'd1);
    end
  endtask

  initial begin
    rst            = 1'b0;
    trans          = '0;
    trans_state    = 2'd0;
    crc_en         = 1'b0;
    sbtx_sel       = 1'b0;
    disconnected_s = 1'b1;
    repeat (2) step();
    check("rst_sbtx", 16'(sbtx), 16'd0);
    check("rst_done", 16'(sym_done), 16'd0);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_crc", crc_value, 16'hFFFF);

    // Released while disconnected: must stay off
    trans_state = 2'd1;
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("off_sbtx", 16'(sbtx), 16'd0);
      check("off_busy", 16'(busy), 16'd0);
    end

    disconnected_s = 1'b0;
    step();
    check("idle_sbtx", 16'(sbtx), 16'd1);
    check("idle_busy", 16'(busy), 16'd0);
    step();
    check("idle_sbtx2", 16'(sbtx), 16'd1);

    // LT sequence
    send_sym("lt0", frame(8'hFE), 1'b0, 1'b0, 10'b1111111100);
    send_sym("lt1", frame(8'h80), 1'b1, 1'b0, 10'b1100000000);
    send_sym("lt2", frame(8'h7F), 1'b1, 1'b0, 10'b1011111110);
    trans_state = 2'd1;
    step();
    check("lt_idle_sbtx", 16'(sbtx), 16'd1);
    check("lt_idle_busy", 16'(busy), 16'd0);
    check("lt_idle_done", 16'(sym_done), 16'd0);

    // AT read command followed by CRC slots
    golden = crc_byte(crc_byte(crc_byte(16'hFFFF, 8'h05), 8'h4E), 8'h03);
    send_sym("at_dle", frame(8'h10), 1'b0, 1'b0, 10'b1000100000);
    send_sym("at_stx", frame(8'h05), 1'b1, 1'b0, 10'b1000001010);
    send_sym("at_4e",  frame(8'h4E), 1'b1, 1'b0, 10'b1010011100);
    send_sym("at_03",  frame(8'h03), 1'b1, 1'b0, 10'b1000000110);
    check("at_crc", crc_value, golden);
    send_sym("crc_hi",  10'h2AA, 1'b1, 1'b1, frame(golden[15:8]));
    check("crc_hold_hi", crc_value, golden);
    send_sym("crc_lo",  10'h2AA, 1'b1, 1'b1, frame(golden[7:0]));
    check("crc_hold_lo", crc_value, golden);
    send_sym("crc_rep", 10'h155, 1'b1, 1'b1, frame(golden[7:0]));
    check("crc_hold_rep", crc_value, golden);

    // Disconnect at bit_cnt=4 of a symbol
    trans    = frame(8'hA5);
    crc_en   = 1'b1;
    sbtx_sel = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("disc_pre_bit4", 16'(sbtx), 16'd0);
    check("disc_pre_busy", 16'(busy), 16'd1);
    disconnected_s = 1'b1;
    step();
    check("disc_sbtx", 16'(sbtx), 16'd0);
    check("disc_busy", 16'(busy), 16'd0);
    check("disc_done", 16'(sym_done), 16'd0);
    check("disc_crc", crc_value, 16'hFFFF);
    step();
    check("disc_sbtx2", 16'(sbtx), 16'd0);

    // Reset in the middle of a symbol
    disconnected_s = 1'b0;
    trans_state    = 2'd1;
    step();
    check("re_idle_sbtx", 16'(sbtx), 16'd1);
    trans       = frame(8'hFF);
    crc_en      = 1'b1;
    trans_state = 2'd2;
    step();
    check("re_start", 16'(sbtx), 16'd0);
    step();
    check("re_bit1", 16'(sbtx), 16'd1);
    step();
    check("re_crc_moved", crc_value, 16'hFFFE);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_sbtx", 16'(sbtx), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    check("mid_rst_crc", crc_value, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mid_rst_hold", 16'(sbtx), 16'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
